// File: rtl/signal_change_recorder.sv
// Change-triggered bus recorder: logs {timestamp, value} on each sample change
// into a first-word-fall-through FIFO drained over a valid/ready port.
module signal_change_recorder #(
    parameter int WIDTH    = 8,
    parameter int TS_WIDTH = 32,
    parameter int DEPTH    = 16,
    parameter int DROP_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         sample_in,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [TS_WIDTH-1:0]      rec_timestamp,
    output logic [WIDTH-1:0]         rec_value,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        dropped_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [TS_WIDTH-1:0] ts_q;
    logic [WIDTH-1:0]    prev_q;
    logic                en_q;

    logic [TS_WIDTH-1:0] ts_mem  [DEPTH];
    logic [WIDTH-1:0]    val_mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level_q;
    logic                overflow_q;
    logic [DROP_W-1:0]   drop_q;

    logic push_req;
    logic pop;
    logic full;
    logic push;
    logic drop;

    // First enabled cycle always logs; afterwards only real changes do.
    assign push_req = enable && (!en_q || (sample_in != prev_q));

    assign full = (level_q == FULL_LEVEL);
    assign pop  = (level_q != '0) && rec_ready;

    // A pop in the same cycle frees the slot the push needs.
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q   <= '0;
            prev_q <= '0;
            en_q   <= 1'b0;
        end else begin
            ts_q   <= ts_q + 1'b1;
            prev_q <= sample_in;
            en_q   <= enable;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ts_mem[wr_ptr]  <= ts_q;
            val_mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                push && !pop: level_q <= level_q + 1'b1;
                pop && !push: level_q <= level_q - 1'b1;
                default:      level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != '1) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign rec_valid     = (level_q != '0);
    assign rec_timestamp = rec_valid ? ts_mem[rd_ptr] : '0;
    assign rec_value     = rec_valid ? val_mem[rd_ptr] : '0;
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign dropped_count = drop_q;

endmodule

// File: tb/tb_signal_change_recorder.sv
// Bench for signal_change_recorder: vector table, directed corner cases and
// randomized traffic compared against a queue-based record model.
module tb_signal_change_recorder;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 4;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  sample_in;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_timestamp;
    logic [7:0]  rec_value;
    logic [4:0]  level;
    logic        overflow;
    logic [DROP_W-1:0] dropped_count;

    signal_change_recorder #(
        .WIDTH(8), .TS_WIDTH(32), .DEPTH(DEPTH), .DROP_W(DROP_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sample_in(sample_in),
        .rec_valid(rec_valid),
        .rec_ready(rec_ready),
        .rec_timestamp(rec_timestamp),
        .rec_value(rec_value),
        .level(level),
        .overflow(overflow),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ts;
        logic [7:0]  v;
    } rec_t;

    rec_t        mq[$];
    logic [31:0] m_ts;
    logic [7:0]  m_prev;
    logic        m_enq;
    logic        m_ovf;
    int          m_drop;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  s;
        logic        rdy;
        logic        ev;
        logic [31:0] ets;
        logic [7:0]  eval;
        int          elev;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        rec_t h;
        h.ts = '0;
        h.v  = '0;
        if (mq.size() != 0) h = mq[0];
        chk("model_valid", rec_valid, mq.size() != 0);
        chk("model_level", level, mq.size());
        chk("model_ts", rec_timestamp, h.ts);
        chk("model_value", rec_value, h.v);
        chk("model_overflow", overflow, m_ovf);
        chk("model_dropped", dropped_count,
            (m_drop > DROP_MAX) ? DROP_MAX : m_drop);
    endtask

    // One clock: apply inputs, advance the model, then check after the edge.
    task automatic drive(input logic r, input logic e, input logic [7:0] s,
                         input logic rd);
        bit want;
        reset     = r;
        enable    = e;
        sample_in = s;
        rec_ready = rd;
        if (r) begin
            mq.delete();
            m_ts = 0; m_prev = 0; m_enq = 0; m_ovf = 0; m_drop = 0;
        end else begin
            want = e && (!m_enq || s != m_prev);
            if (mq.size() != 0 && rd) void'(mq.pop_front());
            if (want) begin
                if (mq.size() < DEPTH) mq.push_back('{m_ts, s});
                else begin
                    m_ovf = 1;
                    m_drop++;
                end
            end
            m_ts   = m_ts + 1;
            m_prev = s;
            m_enq  = e;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sample_in = '0; rec_ready = 1'b0;
        #1;

        tbl.push_back('{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 8'd0, 0});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 32'd0, 8'd0, 1});
        tbl.push_back('{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 8'd0, 0});
        for (int k = 0; k < 6; k++)
            tbl.push_back('{1'b0, 1'b1, 8'(k), 1'b1, 1'b1, 32'(k), 8'(k), 1});
        tbl.push_back('{1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 32'd0, 8'd0, 0});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].s, tbl[i].rdy);
            chk("tbl_valid", rec_valid, tbl[i].ev);
            chk("tbl_ts", rec_timestamp, tbl[i].ets);
            chk("tbl_value", rec_value, tbl[i].eval);
            chk("tbl_level", level, tbl[i].elev);
        end

        // 20 changes with no consumer: 16 kept, 4 dropped.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, 8'(i + 1), 0);
        chk("ovf_level", level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_dropped", dropped_count, 4);
        chk("ovf_head_ts", rec_timestamp, 0);
        chk("ovf_head_val", rec_value, 1);

        // Full FIFO with pop and change together: no drop.
        drive(0, 1, 8'd99, 1);
        chk("full_pp_level", level, 16);
        chk("full_pp_dropped", dropped_count, 4);

        for (int i = 0; i < 16; i++) begin
            chk("drain_ts", rec_timestamp, (i < 15) ? i + 1 : 20);
            chk("drain_val", rec_value, (i < 15) ? i + 2 : 99);
            drive(0, 0, 8'd99, 1);
        end
        chk("drain_empty", rec_valid, 0);

        // Enable gap: change while disabled is not logged, re-arm logs once.
        drive(1, 0, 0, 0);
        for (int t = 0; t <= 20; t++)
            drive(0, (t < 10 || t >= 15), (t >= 12) ? 8'd8 : 8'd7, 0);
        chk("gap_level", level, 2);
        chk("gap_head_ts", rec_timestamp, 0);
        drive(0, 1, 8'd8, 1);
        chk("gap_rearm_ts", rec_timestamp, 15);
        chk("gap_rearm_val", rec_value, 8);

        // Dropped counter saturates.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) drive(0, 1, 8'(i + 1), 0);
        chk("sat_dropped", dropped_count, DROP_MAX);

        // Reset mid-drain at level 7.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, 8'(i + 1), 0);
        drive(0, 0, 8'd9, 1);
        drive(0, 0, 8'd9, 1);
        chk("mid_level", level, 7);
        drive(1, 0, 8'd9, 1);
        chk("rst_valid", rec_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ts", rec_timestamp, 0);
        drive(0, 1, 8'd3, 0);
        chk("rst_ts_restart", rec_timestamp, 0);
        chk("rst_val_restart", rec_value, 3);

        for (int i = 0; i < 3000; i++) begin
            logic r, e, rd;
            logic [7:0] s;
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 9) != 0);
            s  = 8'($urandom_range(0, 3));
            rd = ((i / 300) % 2 == 1) ? ($urandom_range(0, 9) == 0)
                                      : ($urandom_range(0, 1) == 1);
            drive(r, e, s, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
